// File: rtl/seg7_dec_entry.sv
// Seven-segment digit entry: decodes strobed segment codes back to BCD and
// accumulates up to two decimal digits (MSD first) into a binary value 0..99.
module seg7_dec_entry #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] seg,
    input  logic       seg_valid,
    input  logic       clear,
    output logic [6:0] value,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [1:0] count,
    output logic       done,
    output logic       err,
    output logic       drop
);

    typedef enum logic [1:0] {StIdle, StOne, StFull, StErr} state_e;

    state_e     state_q, state_d;
    logic [6:0] value_q, value_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [1:0] count_q, count_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       drop_q, drop_d;

    logic [6:0] code;
    logic [3:0] dig;
    logic       dig_ok;
    logic       blank;
    logic [6:0] ones_ext;

    // Normalise to active-low form so one decode table serves both polarities.
    always_comb begin
        code   = SEG_ACTIVE_LOW ? seg : ~seg;
        dig    = 4'd0;
        dig_ok = 1'b1;
        blank  = 1'b0;
        case (code)
            7'h40: dig = 4'd0;
            7'h79: dig = 4'd1;
            7'h24: dig = 4'd2;
            7'h30: dig = 4'd3;
            7'h19: dig = 4'd4;
            7'h12: dig = 4'd5;
            7'h02: dig = 4'd6;
            7'h78: dig = 4'd7;
            7'h00: dig = 4'd8;
            7'h10: dig = 4'd9;
            7'h7F: begin
                dig_ok = 1'b0;
                blank  = 1'b1;
            end
            default: dig_ok = 1'b0;
        endcase
    end

    assign ones_ext = {3'b000, ones_q};

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        drop_d  = 1'b0;

        if (clear) begin
            state_d = StIdle;
            value_d = 7'd0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
        end else if (seg_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (dig_ok) begin
                        ones_d  = dig;
                        tens_d  = 4'd0;
                        value_d = {3'b000, dig};
                        state_d = StOne;
                    end else if (!blank) begin
                        state_d = StErr;
                    end
                end
                StOne: begin
                    if (dig_ok) begin
                        tens_d  = ones_q;
                        ones_d  = dig;
                        value_d = (ones_ext << 3) + (ones_ext << 1) + {3'b000, dig};
                        state_d = StFull;
                    end else if (!blank) begin
                        state_d = StErr;
                    end
                end
                StFull:  drop_d = 1'b1;
                StErr:   ;
                default: state_d = StIdle;
            endcase
        end
    end

    // Status flags follow the next state; count holds its last value in StErr.
    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_d)
            StIdle:  count_d = 2'd0;
            StOne:   count_d = 2'd1;
            StFull: begin
                count_d = 2'd2;
                done_d  = 1'b1;
            end
            StErr:   err_d = 1'b1;
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            value_q <= 7'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            count_q <= 2'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    assign value = value_q;
    assign tens  = tens_q;
    assign ones  = ones_q;
    assign count = count_q;
    assign done  = done_q;
    assign err   = err_q;
    assign drop  = drop_q;

endmodule
